// File: rtl/freq_meter.sv
// freq_meter: gated edge counter; counts sig_in rising edges over GATE_CYCLES clk cycles
// and reports the total with a one-cycle valid strobe.
module freq_meter #(
   parameter int GATE_CYCLES = 1000,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             start,
   input  logic             cont,
   output logic             busy,
   output logic [CNT_W-1:0] freq_cnt,
   output logic             valid,
   output logic             overflow
);
   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;
   state_t state, state_nxt;

   logic s1, s2, s3, rise, sat, last, ovf, ovf_nxt;
   logic [GW-1:0] gate_cnt;
   logic [CNT_W-1:0] edge_cnt, edge_nxt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, s2, s3} <= '0;
      else {s1, s2, s3} <= {sig_in, s1, s2};

   assign rise = s2 & ~s3;
   assign busy = state != IDLE;

   always_comb begin
      sat      = &edge_cnt;
      last     = state == GATE && gate_cnt == LAST;
      edge_nxt = edge_cnt + CNT_W'(rise & ~sat);
      ovf_nxt  = ovf | (rise & sat);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? GATE : IDLE;
         GATE:    state_nxt = last ? DONE : GATE;
         DONE:    state_nxt = cont ? GATE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // counters are held clear outside GATE, so every gate starts from zero
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
      end else if (state != GATE) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf      <= 1'b0;
      end else begin
         gate_cnt <= gate_cnt + GW'(1);
         edge_cnt <= edge_nxt;
         ovf      <= ovf_nxt;
      end

   // result captured on entry to DONE, including the final gate cycle's edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid    <= 1'b0;
         freq_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         valid <= last;
         if (last) begin
            freq_cnt <= edge_nxt;
            overflow <= ovf_nxt;
         end
      end
endmodule
